// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for serial_wide_adder: FSM state encoding,
// slice-index width and the signed saturation limits used when SERIAL_ADDER_SATURATE_EN is set.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Upper bound on W for the limit helpers; callers slice off the low W bits.
    localparam int SAT_MAX_W = 4096;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // Most positive W-bit signed value, 2^(W-1)-1.
    function automatic logic [SAT_MAX_W-1:0] sat_pos(input int w);
        logic [SAT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < w - 1; i++) begin
            r[i] = 1'b1;
        end
        return r;
    endfunction

    // Most negative W-bit signed value, -2^(W-1).
    function automatic logic [SAT_MAX_W-1:0] sat_neg(input int w);
        logic [SAT_MAX_W-1:0] r;
        r = '0;
        r[w-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/n_adder.sv
// N-bit ripple adder with carry in/out; the slice datapath of serial_wide_adder.
module n_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         c_in,
    output logic [N-1:0] S,
    output logic         c_out
);

    logic [N:0] full;

    always_comb begin
        full  = {1'b0, A} + {1'b0, B} + (N+1)'(c_in);
        S     = full[N-1:0];
        c_out = full[N];
    end

endmodule

// File: rtl/serial_wide_adder.sv
// Wide signed adder that streams N-bit slices (LSB first) through one n_adder.
// Optional clamping of overflowed results to the signed limits: define SERIAL_ADDER_SATURATE_EN.
module serial_wide_adder
    import serial_adder_pkg::*;
#(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] in_a,
    input  logic [N*WORDS-1:0] in_b,
    input  logic               in_cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] out_sum,
    output logic               out_cout,
    output logic               out_ovf,
    output logic               busy,
    output state_e             dbg_state
);

    localparam int W    = N * WORDS;
    localparam int IDXW = idx_width(WORDS);

`ifdef SERIAL_ADDER_SATURATE_EN
    localparam logic [SAT_MAX_W-1:0] SAT_POS_WIDE = sat_pos(W);
    localparam logic [SAT_MAX_W-1:0] SAT_NEG_WIDE = sat_neg(W);
    localparam logic [W-1:0]         SAT_POS      = SAT_POS_WIDE[W-1:0];
    localparam logic [W-1:0]         SAT_NEG      = SAT_NEG_WIDE[W-1:0];
`endif

    // Handshakes: a transfer happens on a posedge where valid and ready are
    // both high. in_ready is high only in IDLE; out_valid only in DONE, and
    // out_sum/out_cout/out_ovf stay stable until out_ready takes the result.

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic [N-1:0]    slice_a;
    logic [N-1:0]    slice_b;
    logic [N-1:0]    slice_s;
    logic            slice_cout;
    logic [W-1:0]    assembled;
    logic            last_slice;
    logic            ovf_now;

    n_adder #(
        .N (N)
    ) u_slice_adder (
        .A     (slice_a),
        .B     (slice_b),
        .c_in  (carry_q),
        .S     (slice_s),
        .c_out (slice_cout)
    );

    always_comb begin
        slice_a   = '0;
        slice_b   = '0;
        assembled = acc_q;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDXW'(i)) begin
                slice_a              = a_q[i*N +: N];
                slice_b              = b_q[i*N +: N];
                assembled[i*N +: N]  = slice_s;
            end
        end
        last_slice = (idx_q == IDXW'(WORDS - 1));
        // Carry into the MSB is recovered from the MSB's sum bit and inputs.
        ovf_now    = slice_cout ^ (a_q[W-1] ^ b_q[W-1] ^ slice_s[N-1]);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = assembled;
                carry_d = slice_cout;
                idx_d   = idx_q + IDXW'(1);
                if (last_slice) begin
                    idx_d   = '0;
                    cout_d  = slice_cout;
                    ovf_d   = ovf_now;
                    sum_d   = assembled;
`ifdef SERIAL_ADDER_SATURATE_EN
                    if (ovf_now) begin
                        sum_d = a_q[W-1] ? SAT_NEG : SAT_POS;
                    end
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_wide_adder.sv
// Directed and randomized checks of serial_wide_adder at N=8, WORDS=4 (W=32).
module tb_serial_wide_adder;
    import serial_adder_pkg::*;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;
    localparam int WAIT_LIMIT = 64;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;
    state_e       dbg_state;

    int n_checks;
    int n_fail;

    serial_wide_adder #(
        .N     (N),
        .WORDS (WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < WAIT_LIMIT) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Scenario tasks
    task automatic test_reset();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (out_sum !== 32'h0) begin n_fail++; $display("FAIL reset_out_sum got %h exp 00000000", out_sum); end
        n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_out_cout got %b exp 0", out_cout); end
        n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf got %b exp 0", out_ovf); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE); end
    endtask

    task automatic test_basic();
        int lat;
        start_op(32'h000000FF, 32'h00000001, 1'b0);
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy got busy=%b in_ready=%b exp 1/0", busy, in_ready); end
        wait_valid(lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency got %0d exp 4", lat); end
        n_checks++; if (out_sum !== 32'h00000100) begin n_fail++; $display("FAIL basic_sum got %h exp 00000100", out_sum); end
        n_checks++; if (out_cout !== 1'b0 || out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_flags got cout=%b ovf=%b exp 0/0", out_cout, out_ovf); end
        consume();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_release got valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
    endtask

    task automatic test_edge_cases();
        logic [W-1:0] a_v [4];
        logic [W-1:0] b_v [4];
        logic         c_v [4];
        logic [W-1:0] s_v [4];
        logic         co_v[4];
        logic         ov_v[4];
        int lat;
        a_v[0] = 32'h7FFFFFFF; b_v[0] = 32'h00000001; c_v[0] = 1'b0; co_v[0] = 1'b0; ov_v[0] = 1'b1;
        a_v[1] = 32'hFFFFFFFF; b_v[1] = 32'hFFFFFFFF; c_v[1] = 1'b1; co_v[1] = 1'b1; ov_v[1] = 1'b0;
        a_v[2] = 32'h80000000; b_v[2] = 32'h80000000; c_v[2] = 1'b0; co_v[2] = 1'b1; ov_v[2] = 1'b1;
        a_v[3] = 32'h0000FFFF; b_v[3] = 32'h00FF0001; c_v[3] = 1'b1; co_v[3] = 1'b0; ov_v[3] = 1'b0;
`ifdef SERIAL_ADDER_SATURATE_EN
        s_v[0] = 32'h7FFFFFFF;
        s_v[2] = 32'h80000000;
`else
        s_v[0] = 32'h80000000;
        s_v[2] = 32'h00000000;
`endif
        s_v[1] = 32'hFFFFFFFF;
        s_v[3] = 32'h01000001;
        for (int i = 0; i < 4; i++) begin
            start_op(a_v[i], b_v[i], c_v[i]);
            wait_valid(lat);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL edge%0d_valid got %b exp 1", i, out_valid); end
            n_checks++; if (out_sum !== s_v[i]) begin n_fail++; $display("FAIL edge%0d_sum got %h exp %h", i, out_sum, s_v[i]); end
            n_checks++; if (out_cout !== co_v[i]) begin n_fail++; $display("FAIL edge%0d_cout got %b exp %b", i, out_cout, co_v[i]); end
            n_checks++; if (out_ovf !== ov_v[i]) begin n_fail++; $display("FAIL edge%0d_ovf got %b exp %b", i, out_ovf, ov_v[i]); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        start_op(32'h12345678, 32'h11111111, 1'b0);
        wait_valid(lat);
        bad = 0;
        in_a     = 32'hDEADBEEF;
        in_b     = 32'h01010101;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_sum !== 32'h23456789 || in_ready !== 1'b0 || busy !== 1'b1)
                bad++;
            tick();
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
        n_checks++; if (out_valid !== 1'b1 || out_sum !== 32'h23456789) begin n_fail++; $display("FAIL bp_still_valid got valid=%b sum=%h exp 1/23456789", out_valid, out_sum); end
        in_valid = 1'b0;
        consume();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release got in_ready=%b valid=%b busy=%b exp 1/0/0", in_ready, out_valid, busy); end
        tick();
        n_checks++; if (busy !== 1'b0 || out_sum !== 32'h23456789) begin n_fail++; $display("FAIL bp_ignored got busy=%b sum=%h exp 0/23456789", busy, out_sum); end
    endtask

    task automatic test_back_to_back();
        int valids;
        int bad;
        valids = 0;
        bad    = 0;
        in_a      = 32'h00000005;
        in_b      = 32'h00000007;
        in_cin    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                valids++;
                if (out_sum !== 32'h0000000C) bad++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (valids != 6) begin n_fail++; $display("FAIL b2b_count got %0d exp 6", valids); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_sum got %0d wrong sums exp 0", bad); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int seen;
        start_op(32'h01020304, 32'h10203040, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        #2;
        n_checks++; if (out_valid !== 1'b0 || out_sum !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state got valid=%b sum=%h in_ready=%b busy=%b exp 0/00000000/1/0", out_valid, out_sum, in_ready, busy); end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrst_no_output got %0d active cycles exp 0", seen); end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W:0]   full;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
        int lat;
        for (int k = 0; k < 200; k++) begin
            a    = W'($urandom_range(32'hFFFFFFFF, 0));
            b    = W'($urandom_range(32'hFFFFFFFF, 0));
            cin  = 1'($urandom_range(1, 0));
            if (k % 16 == 0) b = ~a;
            full     = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            exp_cout = full[W];
            exp_ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
            exp_sum  = full[W-1:0];
`ifdef SERIAL_ADDER_SATURATE_EN
            if (exp_ovf) exp_sum = a[W-1] ? 32'h80000000 : 32'h7FFFFFFF;
`endif
            start_op(a, b, cin);
            wait_valid(lat);
            n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rand%0d_latency got %0d exp 4", k, lat); end
            n_checks++; if (out_sum !== exp_sum) begin n_fail++; $display("FAIL rand%0d_sum a=%h b=%h cin=%b got %h exp %h", k, a, b, cin, out_sum, exp_sum); end
            n_checks++; if (out_cout !== exp_cout) begin n_fail++; $display("FAIL rand%0d_cout got %b exp %b", k, out_cout, exp_cout); end
            n_checks++; if (out_ovf !== exp_ovf) begin n_fail++; $display("FAIL rand%0d_ovf got %b exp %b", k, out_ovf, exp_ovf); end
            consume();
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_basic();
        test_edge_cases();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
